// File: rtl/z80_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z80_bus_ctrl: Z80 BUSRQ/BUSAK handshake, RESET pulse stretcher, ack timeout|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module z80_bus_ctrl #(
  parameter int unsigned RST_MIN     = 16,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic REQ_WR,
  input  logic REQ_D,
  input  logic ZRES_WR,
  input  logic ZRES_D,
  input  logic ZBUSAK,
  output logic ZBUSRQ,
  output logic ZRESET,
  output logic GRANT,
  output logic STAT,
  output logic TIMEOUT
);

  localparam logic [15:0] C_RST_LOAD = 16'(RST_MIN);
  localparam logic [15:0] C_TO_LAST  = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    GRANTED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        run_q, run_d;
  logic        ack_q, ack_d;
  logic        zreset_q, zreset_d;
  logic        timeout_q, timeout_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        hold_wr;
  logic        in_rst;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      run_q     <= 1'b0;
      ack_q     <= 1'b1;
      zreset_q  <= 1'b0;
      timeout_q <= 1'b0;
      rst_cnt_q <= C_RST_LOAD;
      to_cnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      run_q     <= run_d;
      ack_q     <= ack_d;
      zreset_q  <= zreset_d;
      timeout_q <= timeout_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    req_d     = REQ_WR  ? REQ_D  : req_q;
    run_d     = ZRES_WR ? ZRES_D : run_q;
    ack_d     = ZBUSAK;
    hold_wr   = ZRES_WR & ~ZRES_D;
    in_rst    = ~zreset_q;
    rst_cnt_d = rst_cnt_q;
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;

    if (hold_wr) begin
      rst_cnt_d = C_RST_LOAD;
    end else if (in_rst && (rst_cnt_q != 16'd0)) begin
      rst_cnt_d = rst_cnt_q - 16'd1;
    end
    // A release written before the counter expires stays latched in run_q
    zreset_d = run_d && (rst_cnt_q == 16'd0);

    case (state_q)
      IDLE: begin
        if (req_q) begin
          state_d  = WAIT_ACK;
          to_cnt_d = 16'd0;
        end
      end
      WAIT_ACK: begin
        if (!req_q) begin
          state_d = RELEASE;
        end else if (!ack_q || in_rst) begin
          state_d = GRANTED;
        end else if (to_cnt_q == C_TO_LAST) begin
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      GRANTED: begin
        // Z80 leaving reset without BUSAK means the bus was never really ours
        if (!req_q) begin
          state_d = RELEASE;
        end else if (!in_rst && ack_q) begin
          state_d = WAIT_ACK;
        end
      end
      RELEASE: begin
        if (ack_q || in_rst) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (REQ_WR && !REQ_D) begin
      timeout_d = 1'b0;
    end
  end

  assign ZBUSRQ  = ~((state_q == WAIT_ACK) || (state_q == GRANTED));
  assign GRANT   = (state_q == GRANTED);
  assign STAT    = (state_q != GRANTED);
  assign ZRESET  = zreset_q;
  assign TIMEOUT = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_z80_bus_ctrl: scoreboard bench for z80_bus_ctrl (RST_MIN=16, TO=64)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_z80_bus_ctrl;

  logic MCLK = 1'b0;
  logic RESET = 1'b1;
  logic REQ_WR = 1'b0;
  logic REQ_D = 1'b0;
  logic ZRES_WR = 1'b0;
  logic ZRES_D = 1'b0;
  logic ZBUSAK = 1'b1;
  logic ZBUSRQ, ZRESET, GRANT, STAT, TIMEOUT;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [4:0] mask;
    logic [4:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];

  z80_bus_ctrl #(.RST_MIN(16), .ACK_TIMEOUT(64)) dut (
    .MCLK(MCLK), .RESET(RESET), .REQ_WR(REQ_WR), .REQ_D(REQ_D),
    .ZRES_WR(ZRES_WR), .ZRES_D(ZRES_D), .ZBUSAK(ZBUSAK),
    .ZBUSRQ(ZBUSRQ), .ZRESET(ZRESET), .GRANT(GRANT), .STAT(STAT),
    .TIMEOUT(TIMEOUT)
  );

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Output vector order: {ZBUSRQ, ZRESET, GRANT, STAT, TIMEOUT}
  task automatic expect_at(input int at, input string tag, input logic [4:0] mask,
                           input logic [4:0] val);
    exp_t e;
    e.at = at; e.mask = mask; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge MCLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, {ZBUSRQ, ZRESET, GRANT, STAT, TIMEOUT} & sb[i].mask,
              sb[i].val & sb[i].mask);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(negedge MCLK);
    REQ_WR  = 1'b0;
    ZRES_WR = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  int b, s, t, u, v, w;

  initial begin
    tick();
    tick();
    // Block reset: last reset-valued cycle is b, rst_cnt=16 there
    b = cyc + 1;
    expect_at(b, "reset_state", 5'b11111, 5'b10010);
    expect_at(b + 10, "zres_pending", 5'b11000, 5'b10000);
    expect_at(b + 16, "zres_still_low", 5'b11000, 5'b10000);
    expect_at(b + 17, "zres_rise", 5'b11000, 5'b11000);
    wait_until(b);
    RESET = 1'b0;
    wait_until(b + 2);
    ZRES_WR = 1'b1; ZRES_D = 1'b1;

    // Handshake with a running Z80, then straight into the timeout case
    s = b + 20;
    expect_at(s + 1, "busrq_not_yet", 5'b10000, 5'b10000);
    expect_at(s + 2, "busrq_low", 5'b10110, 5'b00010);
    expect_at(s + 6, "grant_not_yet", 5'b00110, 5'b00010);
    expect_at(s + 7, "grant_on_ack", 5'b11110, 5'b01100);
    expect_at(s + 21, "grant_hold", 5'b00110, 5'b00100);
    expect_at(s + 22, "release", 5'b10110, 5'b10010);
    expect_at(s + 26, "no_shortcut", 5'b10000, 5'b10000);
    expect_at(s + 27, "idle_then_wait", 5'b10110, 5'b00010);
    expect_at(s + 60, "wait_no_grant", 5'b10111, 5'b00010);
    expect_at(s + 90, "timeout_not_yet", 5'b00111, 5'b00010);
    expect_at(s + 91, "timeout_set", 5'b10111, 5'b00011);
    wait_until(s);
    REQ_WR = 1'b1; REQ_D = 1'b1;
    wait_until(s + 5);
    ZBUSAK = 1'b0;
    wait_until(s + 20);
    REQ_WR = 1'b1; REQ_D = 1'b0;
    wait_until(s + 24);
    ZBUSAK = 1'b1;
    wait_until(s + 25);
    REQ_WR = 1'b1; REQ_D = 1'b1;
    t = s + 95;
    expect_at(t + 2, "timeout_clear", 5'b10111, 5'b10010);
    wait_until(t);
    REQ_WR = 1'b1; REQ_D = 0;

    // Bus request while the Z80 is held in reset
    u = s + 100;
    expect_at(u + 4, "rst_wait", 5'b10110, 5'b00010);
    expect_at(u + 5, "rst_grant", 5'b01110, 5'b00100);
    expect_at(u + 16, "rst_min_hold", 5'b01000, 5'b00000);
    expect_at(u + 31, "zres_up_granted", 5'b11110, 5'b01100);
    expect_at(u + 32, "grant_drop", 5'b11110, 5'b01010);
    expect_at(u + 34, "grant_wait_ack", 5'b00110, 5'b00010);
    expect_at(u + 35, "grant_reack", 5'b00110, 5'b00100);
    wait_until(u);
    ZRES_WR = 1'b1; ZRES_D = 1'b0;
    wait_until(u + 2);
    REQ_WR = 1'b1; REQ_D = 1'b1;
    wait_until(u + 30);
    ZRES_WR = 1'b1; ZRES_D = 1'b1;
    wait_until(u + 33);
    ZBUSAK = 1'b0;

    // Simultaneous request and hold writes while granted with BUSAK low
    v = u + 40;
    expect_at(v + 1, "both_wr_zres", 5'b01110, 5'b00100);
    expect_at(v + 2, "both_wr_grant", 5'b01110, 5'b00100);
    expect_at(v + 17, "reload_low", 5'b01110, 5'b00100);
    expect_at(v + 18, "reload_rise", 5'b01110, 5'b01100);
    wait_until(v);
    REQ_WR = 1'b1; REQ_D = 1'b1;
    ZRES_WR = 1'b1; ZRES_D = 1'b0;
    wait_until(v + 2);
    ZRES_WR = 1'b1; ZRES_D = 1'b1;

    // Block reset in the middle of a grant
    w = v + 25;
    expect_at(w + 1, "mid_reset", 5'b11111, 5'b10010);
    expect_at(w + 3, "post_reset_idle", 5'b11110, 5'b10010);
    wait_until(w);
    RESET = 1'b1;
    wait_until(w + 1);
    RESET = 1'b0;

    wait_until(w + 6);
    check("pending", 5'(sb.size()), 5'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80_bus_ctrl.md
# z80_bus_ctrl

Bus-ownership and reset controller for the Z80 sub-CPU. It turns the 68k-side bus-request and Z80-reset register writes into the Z80 BUSRQ and RESET pins. It then runs the BUSRQ/BUSAK handshake and tells the 68k side when it may drive the Z80 bus. It also enforces a minimum Z80 reset pulse and flags a BUSAK that never arrives.

## Interface
- RST_MIN, 16: minimum Z80 RESET low time, in MCLK cycles (1..65535)
- ACK_TIMEOUT, 1024: MCLK cycles in WAIT_ACK before TIMEOUT is raised (1..65535)

Ports:
- MCLK  in  1  master clock; the only clock
- RESET  in  1  synchronous, active-high block reset
- REQ_WR  in  1  one-cycle strobe: 68k write to the bus-request register
- REQ_D  in  1  data for REQ_WR: 1 = request Z80 bus, 0 = release it
- ZRES_WR  in  1  one-cycle strobe: 68k write to the Z80-reset register
- ZRES_D  in  1  data for ZRES_WR: 0 = hold Z80 in reset, 1 = run
- ZBUSAK  in  1  Z80 BUSAK pin, active-low
- ZBUSRQ  out  1  Z80 BUSRQ pin, active-low
- ZRESET  out  1  Z80 RESET pin, active-low
- GRANT  out  1  1 = 68k side may drive the Z80 address/data/strobes
- STAT  out  1  readback bit: 0 = bus granted, 1 = not granted (equals ~GRANT)
- TIMEOUT  out  1  sticky: BUSAK not seen within ACK_TIMEOUT

## Operation
- Registers:
  - req_reg (reset 0)
  - run_reg (reset 0)
  - ack_q = ZBUSAK delayed one MCLK (reset 1)
  - rst_cnt, 16 bits
  - to_cnt, 16 bits
  - 2-bit FSM state
- Reset-held condition: `in_rst` = (ZRESET == 0).
- Reset control:
  - ZRES_WR with D=0: run_reg←0; ZRESET drops the next cycle; rst_cnt←RST_MIN.
  - rst_cnt decrements by 1 each cycle while ZRESET=0 and rst_cnt≠0.
  - ZRESET rises only when run_reg=1 and rst_cnt=0.
  - A release written early is held pending; it is not dropped.
  - A hold write while already in reset reloads rst_cnt.
- FSM:
  - IDLE (ZBUSRQ=1): req_reg=1 → WAIT_ACK; to_cnt←0.
  - WAIT_ACK (ZBUSRQ=0):
    - req_reg=0 → RELEASE.
    - else ack_q=0 or in_rst → GRANTED.
    - else to_cnt increments; TIMEOUT←1 when to_cnt reaches ACK_TIMEOUT−1; the FSM stays in WAIT_ACK.
  - GRANTED (ZBUSRQ=0, GRANT=1):
    - req_reg=0 → RELEASE.
    - else !in_rst and ack_q=1 → WAIT_ACK, which covers Z80 leaving reset before acknowledging.
  - RELEASE (ZBUSRQ=1): ack_q=1 or in_rst → IDLE. req_reg re-set here is honoured only after IDLE (no shortcut).
- TIMEOUT clears on REQ_WR with D=0, or on RESET. TIMEOUT never affects the FSM.
- REQ_WR and ZRES_WR in the same cycle are both applied independently.
- All outputs decode from registers only (no input-to-output combinational path).

## Timing
- Reset values:
  - ZBUSRQ=1, ZRESET=0 (Z80 held at power-on), GRANT=0, STAT=1, TIMEOUT=0.
  - FSM=IDLE, rst_cnt=RST_MIN.
- A RESET asserted mid-handshake forces these values on the next edge, whatever the state.
- REQ_WR(D=1) in cycle n: req_reg=1 in n+1; ZBUSRQ=0 in n+2.
- ZBUSAK falls in cycle m while in WAIT_ACK: ack_q=0 in m+1; GRANT=1 and STAT=0 in m+2.
- Bus request while ZRESET=0: GRANT=1 one cycle after entering WAIT_ACK.
- REQ_WR(D=0) in cycle n while GRANTED: GRANT=0 and ZBUSRQ=1 in n+2.
- IDLE is reached 2 cycles after ZBUSAK rises.
- ZRES_WR(D=1) with an expired counter: ZRESET=1 at n+1. With a running counter: ZRESET rises the cycle after rst_cnt reaches 0.
- ZRESET=0 lasts at least RST_MIN cycles after any hold write.
- ZRESET rising while GRANTED with ack_q=1: GRANT falls the next cycle.

## Test plan
- RST_MIN=16: release RESET, then write ZRES_D=1 at cycle 2 → ZRESET stays 0 until rst_cnt=0 (16 cycles after block reset), then rises; ZBUSRQ=1 throughout.
- Z80 running: REQ_WR(1) at cycle 0, model drives ZBUSAK=0 at cycle 5 → ZBUSRQ=0 at cycle 2; GRANT=1 and STAT=0 at cycle 7. REQ_WR(0) at cycle 20 → GRANT=0 and ZBUSRQ=1 at cycle 22; ZBUSAK=1 at 24 → IDLE at 26.
- Z80 in reset: REQ_WR(1) → GRANT=1 at cycle 3 without any BUSAK. Then ZRES_WR(1) with ZBUSAK held 1 → GRANT drops to 0 one cycle after ZRESET rises. ZBUSAK=0 two cycles later → GRANT=1.
- ACK_TIMEOUT=64: REQ_WR(1), ZBUSAK never asserts → TIMEOUT=1 after 64 WAIT_ACK cycles, GRANT stays 0. REQ_WR(0) → TIMEOUT=0 two cycles later.
- REQ_WR(1) and ZRES_WR(0) in the same cycle from GRANTED-with-ack → ZRESET falls at n+1, GRANT stays 1, rst_cnt reloads to RST_MIN.
- RESET asserted while GRANTED → next edge: GRANT=0, ZBUSRQ=1, ZRESET=0, TIMEOUT=0, FSM=IDLE.
